// File: rtl/ysyx_22040088_decode_stage_pkg.sv
// Shared decode definitions: opcodes, ALU one-hot indices, memory/branch codes
// and the packed control bundle carried from decode to the main/skid registers.
package ysyx_22040088_defs;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
   localparam logic [6:0] OPC_OPW    = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam int unsigned ALU_W = 11;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;
   localparam logic [1:0] MEM_D = 2'd3;

   localparam logic [1:0] SRC1_RS1  = 2'b01;
   localparam logic [1:0] SRC1_PC   = 2'b10;
   localparam logic [2:0] SRC2_RS2  = 3'b001;
   localparam logic [2:0] SRC2_IMM  = 3'b010;
   localparam logic [2:0] SRC2_FOUR = 3'b100;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6,
      BR_JMP  = 3'd7
   } br_e;

   // imm is always carried at 64 bits; the stage truncates to XLEN.
   typedef struct packed {
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [63:0]      imm;
      logic [ALU_W-1:0] alu_op;
      logic             word;
      logic             rf_we;
      logic [1:0]       src1;
      logic [2:0]       src2;
      logic             mem_ren;
      logic             mem_wen;
      logic [1:0]       mem_size;
      logic             mem_uns;
      br_e              br;
      logic             illegal;
      logic             ebreak;
   } dec_bundle_t;

   localparam int unsigned DEC_W = $bits(dec_bundle_t);

endpackage

// File: rtl/ysyx_22040088_decode_stage_comb.sv
// Pure combinational RV32I/RV64I decoder producing the control bundle.
module ysyx_22040088_decode_comb
   import ysyx_22040088_defs::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned EN_RV64 = 1
) (
   input  logic [31:0] inst_i,
   output dec_bundle_t bundle_o
);

   localparam bit XL64 = (XLEN == 64);
   localparam bit RV64 = (EN_RV64 != 0) && XL64;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  aop;
   logic        aop_en;
   logic        ill;
   dec_bundle_t b;

   assign opc   = inst_i[6:0];
   assign f3    = inst_i[14:12];
   assign f7    = inst_i[31:25];
   assign imm_i = {{52{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
   assign imm_j = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      b        = '0;
      b.rd     = inst_i[11:7];
      b.rs1    = inst_i[19:15];
      b.rs2    = inst_i[24:20];
      b.src1   = SRC1_RS1;
      b.src2   = SRC2_RS2;
      aop      = ALU_ADD;
      aop_en   = 1'b1;
      ill      = 1'b0;
      unique case (opc)
         OPC_LUI: begin
            aop = ALU_PASS; b.src1 = '0; b.src2 = SRC2_IMM; b.imm = imm_u; b.rf_we = 1'b1;
         end
         OPC_AUIPC: begin
            b.src1 = SRC1_PC; b.src2 = SRC2_IMM; b.imm = imm_u; b.rf_we = 1'b1;
         end
         OPC_JAL: begin
            b.src1 = SRC1_PC; b.src2 = SRC2_FOUR; b.imm = imm_j; b.rf_we = 1'b1; b.br = BR_JMP;
         end
         OPC_JALR: begin
            b.src1 = SRC1_PC; b.src2 = SRC2_FOUR; b.imm = imm_i; b.rf_we = 1'b1; b.br = BR_JMP;
            ill = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            b.imm = imm_b;
            unique case (f3)
               3'b000: begin aop = ALU_SUB;  b.br = BR_BEQ;  end
               3'b001: begin aop = ALU_SUB;  b.br = BR_BNE;  end
               3'b100: begin aop = ALU_SLT;  b.br = BR_BLT;  end
               3'b101: begin aop = ALU_SLT;  b.br = BR_BGE;  end
               3'b110: begin aop = ALU_SLTU; b.br = BR_BLTU; end
               3'b111: begin aop = ALU_SLTU; b.br = BR_BGEU; end
               default: ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            b.src2 = SRC2_IMM; b.imm = imm_i; b.rf_we = 1'b1; b.mem_ren = 1'b1;
            b.mem_size = f3[1:0]; b.mem_uns = f3[2];
            if (f3 == 3'b111) ill = 1'b1;
            else if (f3 == 3'b011 || f3 == 3'b110) ill = !RV64;
         end
         OPC_STORE: begin
            b.src2 = SRC2_IMM; b.imm = imm_s; b.mem_wen = 1'b1; b.mem_size = f3[1:0];
            if (f3[2]) ill = 1'b1;
            else if (f3[1:0] == MEM_D) ill = !RV64;
         end
         OPC_OPIMM: begin
            b.src2 = SRC2_IMM; b.imm = imm_i; b.rf_we = 1'b1;
            unique case (f3)
               3'b000: aop = ALU_ADD;
               3'b010: aop = ALU_SLT;
               3'b011: aop = ALU_SLTU;
               3'b100: aop = ALU_XOR;
               3'b110: aop = ALU_OR;
               3'b111: aop = ALU_AND;
               3'b001: begin
                  aop = ALU_SLL;
                  ill = XL64 ? (f7[6:1] != 6'b0) : (f7 != 7'b0);
               end
               default: begin
                  // 6-bit shamt on RV64 frees inst[25], so only funct7[6:1] selects srl/sra
                  if (XL64 ? (f7[6:1] == 6'b000000) : (f7 == 7'b0000000)) aop = ALU_SRL;
                  else if (XL64 ? (f7[6:1] == 6'b010000) : (f7 == 7'b0100000)) aop = ALU_SRA;
                  else ill = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            b.rf_we = 1'b1;
            unique case ({f7, f3})
               10'b0000000_000: aop = ALU_ADD;
               10'b0100000_000: aop = ALU_SUB;
               10'b0000000_001: aop = ALU_SLL;
               10'b0000000_010: aop = ALU_SLT;
               10'b0000000_011: aop = ALU_SLTU;
               10'b0000000_100: aop = ALU_XOR;
               10'b0000000_101: aop = ALU_SRL;
               10'b0100000_101: aop = ALU_SRA;
               10'b0000000_110: aop = ALU_OR;
               10'b0000000_111: aop = ALU_AND;
               default:         ill = 1'b1;
            endcase
         end
         OPC_OPIMMW: begin
            b.src2 = SRC2_IMM; b.imm = imm_i; b.rf_we = 1'b1; b.word = 1'b1;
            unique case ({f7, f3})
               10'b0000000_001: aop = ALU_SLL;
               10'b0000000_101: aop = ALU_SRL;
               10'b0100000_101: aop = ALU_SRA;
               default: begin
                  aop = ALU_ADD;
                  ill = (f3 != 3'b000);
               end
            endcase
            if (!RV64) ill = 1'b1;
         end
         OPC_OPW: begin
            b.rf_we = 1'b1; b.word = 1'b1;
            unique case ({f7, f3})
               10'b0000000_000: aop = ALU_ADD;
               10'b0100000_000: aop = ALU_SUB;
               10'b0000000_001: aop = ALU_SLL;
               10'b0000000_101: aop = ALU_SRL;
               10'b0100000_101: aop = ALU_SRA;
               default:         ill = 1'b1;
            endcase
            if (!RV64) ill = 1'b1;
         end
         OPC_SYSTEM: begin
            aop_en   = 1'b0;
            b.ebreak = (inst_i == INST_EBREAK);
            ill      = (inst_i != INST_EBREAK);
         end
         default: ill = 1'b1;
      endcase
      b.alu_op = aop_en ? (ALU_W'(1) << aop) : '0;
      if (ill) begin
         b.rf_we   = 1'b0;
         b.mem_ren = 1'b0;
         b.mem_wen = 1'b0;
         b.br      = BR_NONE;
         b.alu_op  = '0;
         b.word    = 1'b0;
      end
      b.illegal = ill;
   end

   assign bundle_o = b;

endmodule

// File: rtl/ysyx_22040088_decode_stage.sv
// Decode stage: one decoder feeding a main output register plus a skid entry,
// so in_ready is a pure register and never sees out_ready combinationally.
module ysyx_22040088_decode_stage
   import ysyx_22040088_defs::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned PC_W    = 64,
   parameter int unsigned EN_RV64 = 1,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [XLEN-1:0]  out_imm,
   output logic [10:0]      out_alu_op,
   output logic             out_word,
   output logic             out_rf_we,
   output logic [1:0]       out_src1,
   output logic [2:0]       out_src2,
   output logic             out_mem_ren,
   output logic             out_mem_wen,
   output logic [1:0]       out_mem_size,
   output logic             out_mem_uns,
   output logic [2:0]       out_br,
   output logic             out_illegal,
   output logic             out_ebreak,
   output logic [CNT_W-1:0] dec_cnt
);

   dec_bundle_t      dec;
   dec_bundle_t      main_q, main_d, skid_q, skid_d;
   logic [PC_W-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             rdy_q, rdy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc, fire;

   ysyx_22040088_decode_comb #(
      .XLEN    (XLEN),
      .EN_RV64 (EN_RV64)
   ) u_dec (
      .inst_i   (in_inst),
      .bundle_o (dec)
   );

   assign in_ready = rdy_q & ~rst;
   assign acc      = in_valid & in_ready;
   assign fire     = main_valid_q & out_ready;

   always_comb begin
      main_d       = main_q;
      main_pc_d    = main_pc_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_pc_d    = skid_pc_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (fire) cnt_d = cnt_q + CNT_W'(1);
         if (fire || !main_valid_q) begin
            // skid drains first; acc cannot coincide because in_ready is low then
            if (skid_valid_q) begin
               main_d       = skid_q;
               main_pc_d    = skid_pc_q;
               main_valid_d = 1'b1;
               skid_valid_d = 1'b0;
            end else if (acc) begin
               main_d       = dec;
               main_pc_d    = in_pc;
               main_valid_d = 1'b1;
            end else begin
               main_valid_d = 1'b0;
            end
         end else if (acc) begin
            skid_d       = dec;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
         end
      end
      rdy_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         main_pc_q    <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         rdy_q        <= 1'b1;
         cnt_q        <= '0;
      end else begin
         main_q       <= main_d;
         main_pc_q    <= main_pc_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_pc_q    <= skid_pc_d;
         skid_valid_q <= skid_valid_d;
         rdy_q        <= rdy_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid    = main_valid_q;
   assign out_pc       = main_pc_q;
   assign out_rd       = main_q.rd;
   assign out_rs1      = main_q.rs1;
   assign out_rs2      = main_q.rs2;
   assign out_imm      = main_q.imm[XLEN-1:0];
   assign out_alu_op   = main_q.alu_op;
   assign out_word     = main_q.word;
   assign out_rf_we    = main_q.rf_we;
   assign out_src1     = main_q.src1;
   assign out_src2     = main_q.src2;
   assign out_mem_ren  = main_q.mem_ren;
   assign out_mem_wen  = main_q.mem_wen;
   assign out_mem_size = main_q.mem_size;
   assign out_mem_uns  = main_q.mem_uns;
   assign out_br       = main_q.br;
   assign out_illegal  = main_q.illegal;
   assign out_ebreak   = main_q.ebreak;
   assign dec_cnt      = cnt_q;

endmodule
